// File: rtl/usb_disk_mem_arbiter.sv
// Arbitrates the byte-wide disk memory between the unstallable USB port and a local requester.
// Optional build macro USB_DISK_ARB_WRPROT_EN enables USB-side write protection via wp/wp_hit.
module usb_disk_mem_arbiter #(
  parameter int HOLD_CYCLES = 64,
  parameter int AW          = 41
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] u_addr,
  input  logic          u_wen,
  input  logic [7:0]    u_wdata,
  output logic [7:0]    u_rdata,
  input  logic          l_req,
  input  logic          l_wen,
  input  logic [AW-1:0] l_addr,
  input  logic [7:0]    l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [7:0]    l_rdata,
  output logic [AW-1:0] m_addr,
  output logic          m_wen,
  output logic [7:0]    m_wdata,
  input  logic [7:0]    m_rdata,
  input  logic          wp,
  output logic          wp_hit,
  output logic          usb_busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES);

  logic [AW-1:0] u_addr_q, u_addr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          l_rvalid_q, l_rvalid_d;
  logic          wp_hit_q, wp_hit_d;
  logic          usb_act;
  logic          busy;
  logic          wr_block;

  // State register: the hold counter is the ownership state (0 = FREE, >0 = USB).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      u_addr_q   <= '0;
      hold_cnt_q <= '0;
      l_rvalid_q <= 1'b0;
      wp_hit_q   <= 1'b0;
    end else begin
      u_addr_q   <= u_addr_d;
      hold_cnt_q <= hold_cnt_d;
      l_rvalid_q <= l_rvalid_d;
      wp_hit_q   <= wp_hit_d;
    end
  end

  // The USB controller never issues a stall-able request, so an address change or write is activity.
  always_comb begin
    u_addr_d   = u_addr;
    usb_act    = u_wen | (u_addr != u_addr_q);
    busy       = usb_act | (hold_cnt_q != '0);
    hold_cnt_d = hold_cnt_q;
    if (usb_act) begin
      hold_cnt_d = HOLD_LD;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end
    // Memory latency is 1, so the data returned next cycle belongs to this grant even if USB takes over.
    l_rvalid_d = l_gnt & ~l_wen;
`ifdef USB_DISK_ARB_WRPROT_EN
    wr_block = wp;
    wp_hit_d = wp_hit_q | (u_wen & wp);
`else
    // wp has no effect in this build.
    wr_block = wp & 1'b0;
    wp_hit_d = 1'b0;
`endif
  end

  always_comb begin
    l_gnt   = rstn & ~busy & l_req;
    m_addr  = u_addr;
    m_wdata = u_wdata;
    m_wen   = 1'b0;
    if (busy) begin
      m_wen = u_wen & ~wr_block;
    end else if (l_gnt) begin
      m_addr  = l_addr;
      m_wen   = l_wen;
      m_wdata = l_wdata;
    end
    if (!rstn) begin
      m_wen = 1'b0;
    end
  end

  assign usb_busy = busy;
  assign l_rvalid = l_rvalid_q;
  assign wp_hit   = wp_hit_q;
  assign u_rdata  = m_rdata;
  assign l_rdata  = m_rdata;

endmodule

// File: tb/tb_usb_disk_mem_arbiter.sv
// Scoreboard bench for usb_disk_mem_arbiter with HOLD_CYCLES=4 and a 1-cycle synchronous memory model.
module tb_usb_disk_mem_arbiter;
  localparam int H  = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] u_addr;
  logic          u_wen;
  logic [7:0]    u_wdata;
  logic [7:0]    u_rdata;
  logic          l_req;
  logic          l_wen;
  logic [AW-1:0] l_addr;
  logic [7:0]    l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [7:0]    l_rdata;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [7:0]    m_wdata;
  logic [7:0]    m_rdata;
  logic          wp;
  logic          wp_hit;
  logic          usb_busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  logic [7:0]    mem [0:65535];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;

`ifdef USB_DISK_ARB_WRPROT_EN
  localparam logic [7:0] EXP_MEM40 = 8'h12;
  localparam logic       EXP_HIT   = 1'b1;
  localparam logic       EXP_WEN   = 1'b0;
`else
  localparam logic [7:0] EXP_MEM40 = 8'h77;
  localparam logic       EXP_HIT   = 1'b0;
  localparam logic       EXP_WEN   = 1'b1;
`endif

  usb_disk_mem_arbiter #(.HOLD_CYCLES(H), .AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .u_addr(u_addr), .u_wen(u_wen), .u_wdata(u_wdata), .u_rdata(u_rdata),
    .l_req(l_req), .l_wen(l_wen), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .wp(wp), .wp_hit(wp_hit), .usb_busy(usb_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (m_wen) mem[m_addr] <= m_wdata;
    m_rdata <= mem[m_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int start, output int n);
    n = start;
    while (!l_gnt && n < 30) begin
      tick();
      n++;
    end
  endtask

  // Monitor: every local read return is matched against the scoreboard.
  always @(negedge clk) begin
    if (rstn && l_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected: got rdata 0x%0h with rvalid, required no rvalid", l_rdata);
      end else begin
        chk("l_rdata", {56'd0, l_rdata}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [AW-1:0] pa [6];
    logic [7:0]    pd [6];
    pa = '{16'h0100, 16'h0300, 16'h0020, 16'h0400, 16'h0040, 16'h0500};
    pd = '{8'hA5, 8'h5A, 8'h11, 8'hC3, 8'h12, 8'h6E};
    rstn = 1'b0; u_addr = '0; u_wen = 1'b0; u_wdata = '0;
    l_req = 1'b0; l_wen = 1'b0; l_addr = '0; l_wdata = '0; wp = 1'b0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 6; i++) begin
      pre_en = 1'b1; pre_addr = pa[i]; pre_data = pd[i];
      tick();
    end
    pre_en = 1'b0;

    // Reset state: a pending local write must not be granted or reach memory.
    l_req = 1'b1; l_wen = 1'b1; l_addr = 16'h0020;
    #1;
    chk("rst_l_gnt", l_gnt, 0);
    chk("rst_m_wen", m_wen, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_wp_hit", wp_hit, 0);
    chk("rst_hold_cnt", dut.hold_cnt_q, 0);
    l_req = 1'b0; l_wen = 1'b0;
    tick(); rstn = 1'b1;
    tick();

    // Idle local read.
    l_req = 1'b1; l_wen = 1'b0; l_addr = 16'h0100;
    #1;
    chk("t1_gnt", l_gnt, 1);
    chk("t1_m_addr", m_addr, 16'h0100);
    if (l_gnt) exp_q.push_back(8'hA5);
    tick(); l_req = 1'b0;
    #1;
    chk("t1_rvalid", l_rvalid, 1);
    tick();

    // USB preemption of a pending local read.
    u_addr = 16'h0200; l_req = 1'b1; l_addr = 16'h0300; l_wen = 1'b0;
    #1;
    chk("t2_gnt_a", l_gnt, 0);
    tick(); u_addr = 16'h0201;
    #1;
    chk("t2_gnt_b", l_gnt, 0);
    chk("t2_m_addr_usb", m_addr, 16'h0201);
    wait_gnt(0, n);
    chk("t2_latency", n, H + 1);
    chk("t2_m_addr_gnt", m_addr, 16'h0300);
    if (l_gnt) exp_q.push_back(8'h5A);
    tick(); l_req = 1'b0;
    tick();

    // USB write wins over a pending local write.
    u_addr = 16'h0010; u_wen = 1'b1; u_wdata = 8'h3C;
    l_req = 1'b1; l_wen = 1'b1; l_addr = 16'h0020; l_wdata = 8'h99;
    #1;
    chk("t3_gnt", l_gnt, 0);
    chk("t3_m_wen", m_wen, 1);
    chk("t3_m_addr", m_addr, 16'h0010);
    chk("t3_m_wdata", m_wdata, 8'h3C);
    tick(); u_wen = 1'b0;
    #1;
    chk("t3_mem10", mem[16'h0010], 8'h3C);
    chk("t3_mem20_pre", mem[16'h0020], 8'h11);
    wait_gnt(1, n);
    chk("t3_latency", n, H + 1);
    chk("t3_mem20_hold", mem[16'h0020], 8'h11);
    tick(); l_req = 1'b0; l_wen = 1'b0;
    #1;
    chk("t3_mem20_post", mem[16'h0020], 8'h99);
    chk("t3_no_rvalid", l_rvalid, 0);
    tick();

    // Local read straddling a USB takeover.
    l_req = 1'b1; l_wen = 1'b0; l_addr = 16'h0400;
    #1;
    chk("t4_gnt", l_gnt, 1);
    if (l_gnt) exp_q.push_back(8'hC3);
    tick(); l_req = 1'b0; u_addr = 16'h0011;
    #1;
    chk("t4_rvalid", l_rvalid, 1);
    chk("t4_m_addr", m_addr, 16'h0011);
    chk("t4_busy", usb_busy, 1);
    tick();

    // Write protect (outcome depends on the build macro).
    repeat (6) tick();
    u_addr = 16'h0040; u_wen = 1'b1; u_wdata = 8'h77; wp = 1'b1;
    #1;
    chk("t5_m_wen", m_wen, EXP_WEN);
    tick(); u_wen = 1'b0; wp = 1'b0;
    #1;
    chk("t5_mem40", mem[16'h0040], EXP_MEM40);
    chk("t5_wp_hit", wp_hit, EXP_HIT);
    repeat (3) tick();
    chk("t5_wp_hit_sticky", wp_hit, EXP_HIT);

    // Reset in the cycle after a local read grant.
    repeat (6) tick();
    l_req = 1'b1; l_wen = 1'b0; l_addr = 16'h0500;
    #1;
    chk("t6_gnt", l_gnt, 1);
    tick(); rstn = 1'b0; l_wen = 1'b1;
    #1;
    chk("t6_rvalid", l_rvalid, 0);
    chk("t6_gnt_rst", l_gnt, 0);
    chk("t6_m_wen_rst", m_wen, 0);
    chk("t6_hold_rst", dut.hold_cnt_q, 0);
    l_req = 1'b0; l_wen = 1'b0; u_addr = 16'h0041;
    tick(); rstn = 1'b1;
    #1;
    chk("t6_busy_release", usb_busy, 1);
    tick();
    chk("t6_hold_loaded", dut.hold_cnt_q, H);
    rstn = 1'b0;
    #1;
    chk("t6_hold_cleared", dut.hold_cnt_q, 0);
    tick(); rstn = 1'b1;
    repeat (2) tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
